// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO write arbiter.
package pio_arb_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, DWELL} state_e;

   localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
   localparam int         PIO_BUS_W     = 32;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pio_write_arbiter_if.sv
// Requester handshake plus Avalon-MM write side of the PIO arbiter.
interface pio_write_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   import pio_arb_pkg::*;

   localparam int IW = idx_w(NREQ);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic [1:0]           avm_address;
   logic                 avm_chipselect;
   logic                 avm_write_n;
   logic [PIO_BUS_W-1:0] avm_writedata;
   logic [IW-1:0]        grant_id;
   logic                 busy;
   logic [DW-1:0]        cur_value;

   modport slave (
      input  req_valid, req_data,
      output req_ready, avm_address, avm_chipselect, avm_write_n, avm_writedata,
             grant_id, busy, cur_value
   );

   modport master (
      output req_valid, req_data,
      input  req_ready, avm_address, avm_chipselect, avm_write_n, avm_writedata,
             grant_id, busy, cur_value
   );

endinterface

// File: rtl/pio_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt_oh,
   output logic [IW-1:0]   gnt_idx,
   output logic            any
);

   always_comb begin
      int k;
      logic [IW-1:0] idx;
      k       = 0;
      idx     = '0;
      gnt_oh  = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         k = int'(ptr) + i;
         if (k >= NREQ) k = k - NREQ;
         idx = IW'(k);
         if (!any && req[idx]) begin
            any          = 1'b1;
            gnt_idx      = idx;
            gnt_oh[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter turning requester grants into single-cycle PIO writes.
// Optional post-write dwell enabled by defining PIO_ARB_DWELL_EN.
//
// state | meaning
// IDLE  | waiting for any req_valid; picks and captures on the edge
// WRITE | one Avalon write cycle presented, ready pulsed to the winner
// DWELL | post-write hold-off, requests ignored (PIO_ARB_DWELL_EN only)
module pio_write_arbiter
   import pio_arb_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int DW           = 8,
   parameter int DWELL_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   pio_write_arbiter_if.slave  bus
);

   localparam int IW = idx_w(NREQ);

   state_e               state_q, state_d;
   logic                 cs_q, cs_d;
   logic                 wn_q, wn_d;
   logic [PIO_BUS_W-1:0] wdata_q, wdata_d;
   logic [NREQ-1:0]      ready_q, ready_d;
   logic [IW-1:0]        grant_q, grant_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic                 busy_q, busy_d;
   logic [DW-1:0]        cur_q, cur_d;
`ifdef PIO_ARB_DWELL_EN
   localparam int CW = idx_w(DWELL_CYCLES + 1);
   logic [CW-1:0]        cnt_q, cnt_d;
`endif

   logic [NREQ-1:0] gnt_oh;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req     (bus.req_valid),
      .ptr     (ptr_q),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   always_comb begin
      state_d = state_q;
      cs_d    = 1'b0;
      wn_d    = 1'b1;
      ready_d = '0;
      wdata_d = wdata_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cur_d   = cur_q;
`ifdef PIO_ARB_DWELL_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               state_d = WRITE;
               cs_d    = 1'b1;
               wn_d    = 1'b0;
               ready_d = gnt_oh;
               grant_d = gnt_idx;
               wdata_d = PIO_BUS_W'(bus.req_data[int'(gnt_idx)*DW +: DW]);
            end
         end
         WRITE: begin
            cur_d   = wdata_q[DW-1:0];
            ptr_d   = (grant_q == IW'(NREQ-1)) ? '0 : grant_q + 1'b1;
            state_d = IDLE;
`ifdef PIO_ARB_DWELL_EN
            if (DWELL_CYCLES > 0) begin
               state_d = DWELL;
               cnt_d   = CW'(DWELL_CYCLES - 1);
            end
`endif
         end
         DWELL: begin
`ifdef PIO_ARB_DWELL_EN
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cs_q    <= 1'b0;
         wn_q    <= 1'b1;
         wdata_q <= '0;
         ready_q <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         cur_q   <= '0;
`ifdef PIO_ARB_DWELL_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cs_q    <= cs_d;
         wn_q    <= wn_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         cur_q   <= cur_d;
`ifdef PIO_ARB_DWELL_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign bus.avm_address    = PIO_DATA_ADDR;
   assign bus.avm_chipselect = cs_q;
   assign bus.avm_write_n    = wn_q;
   assign bus.avm_writedata  = wdata_q;
   assign bus.req_ready      = ready_q;
   assign bus.grant_id       = grant_q;
   assign bus.busy           = busy_q;
   assign bus.cur_value      = cur_q;

endmodule
